// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Binary index of the set bit in a one-hot vector; zero when no bit is set.
  function automatic logic [31:0] oh2bin(input logic [31:0] oh);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) b = b | i[31:0];
    end
    return b;
  endfunction

  // Rotate left by one position within the low n bits.
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < n) r[(i + 1) % n] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_n_input.sv
// Combinational rotating-priority picker: first set req at or after the one-hot base, wrapping.
module Arb_n_Input #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] base,
  output logic [N-1:0] gnt
);

  logic [2*N-1:0] dreq;
  logic [2*N-1:0] dgnt;

  // The borrow from subtracting base stops at the first requester at/after base.
  assign dreq = {req, req};
  assign dgnt = dreq & ~(dreq - {{N{1'b0}}, base});
  assign gnt  = dgnt[N-1:0] | dgnt[2*N-1:N];

endmodule

// File: rtl/wrr_arb_hold.sv
// Weighted round-robin arbiter; the winner holds a registered grant until its last beat or abort.
module wrr_arb_hold
  import arb_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int WEIGHT_W = 4,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*WEIGHT_W-1:0]   weight,
  input  logic                          gnt_ready,
  input  logic                          gnt_last,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          gnt_valid,
  output logic [ID_W-1:0]               gnt_id
);

  state_t                state;
  logic [NUM_REQ-1:0]    ptr;
  logic [WEIGHT_W-1:0]   credit [NUM_REQ];

  logic [NUM_REQ-1:0]    pick;
  logic [31:0]           pick_id32;
  logic [ID_W-1:0]       pick_id;
  logic [31:0]           own_rot32;
  logic [NUM_REQ-1:0]    own_next;
  logic [WEIGHT_W-1:0]   win_w;
  logic [WEIGHT_W-1:0]   load_w;
  logic [WEIGHT_W-1:0]   cur_credit;
  logic [WEIGHT_W-1:0]   credit_dec;
  logic                  req_own;
  logic                  beat_end;

  Arb_n_Input #(.N(NUM_REQ)) u_pick (
    .req  (req),
    .base (ptr),
    .gnt  (pick)
  );

  assign pick_id32 = oh2bin(32'(pick));
  assign pick_id   = pick_id32[ID_W-1:0];
  assign own_rot32 = rotl(32'(gnt), NUM_REQ);
  assign own_next  = own_rot32[NUM_REQ-1:0];
  assign req_own   = |(req & gnt);
  assign beat_end  = gnt_valid & gnt_ready & gnt_last;

  always_comb begin
    win_w      = weight[pick_id*WEIGHT_W +: WEIGHT_W];
    load_w     = (win_w == '0) ? WEIGHT_W'(1) : win_w;
    cur_credit = credit[gnt_id];
    // Guarded so a stale zero credit can never wrap around.
    credit_dec = (cur_credit != '0) ? cur_credit - WEIGHT_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      ptr       <= NUM_REQ'(1);
      for (int i = 0; i < NUM_REQ; i++) credit[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state     <= BUSY;
            gnt       <= pick;
            gnt_valid <= 1'b1;
            gnt_id    <= pick_id;
            if (credit[pick_id] == '0) credit[pick_id] <= load_w;
          end
        end
        BUSY: begin
          if (beat_end) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            if (credit_dec == '0 || !req_own) begin
              ptr            <= own_next;
              credit[gnt_id] <= '0;
            end else begin
              // Owner keeps top priority to spend its remaining credit.
              ptr            <= gnt;
              credit[gnt_id] <= credit_dec;
            end
          end else if (!req_own) begin
            state          <= IDLE;
            gnt            <= '0;
            gnt_valid      <= 1'b0;
            gnt_id         <= '0;
            ptr            <= own_next;
            credit[gnt_id] <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wrr_arb_hold.sv
// Scoreboard bench for wrr_arb_hold: grant order queued at stimulus, popped on each new grant.
module tb_wrr_arb_hold;

  localparam int NUM_REQ  = 4;
  localparam int WEIGHT_W = 4;
  localparam int ID_W     = 2;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*WEIGHT_W-1:0] weight;
  logic                        gnt_ready;
  logic                        gnt_last;
  logic [NUM_REQ-1:0]          gnt;
  logic                        gnt_valid;
  logic [ID_W-1:0]             gnt_id;

  int checks = 0;
  int errors = 0;
  logic [NUM_REQ-1:0] sb [$];

  wrr_arb_hold #(.NUM_REQ(NUM_REQ), .WEIGHT_W(WEIGHT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .weight    (weight),
    .gnt_ready (gnt_ready),
    .gnt_last  (gnt_last),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] oh_to_id(input logic [NUM_REQ-1:0] oh);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < NUM_REQ; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    gnt_ready = 1'b0;
    gnt_last = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Every new grant (rising out of an idle cycle) must match the next queued winner.
  initial begin
    logic [NUM_REQ-1:0] prev;
    logic [NUM_REQ-1:0] e;
    prev = '0;
    forever begin
      @(posedge clk);
      #1;
      if (gnt != '0 && prev == '0) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected", 32'(gnt), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_gnt", 32'(gnt), 32'(e));
          chk("sb_id", 32'(gnt_id), oh_to_id(e));
          chk("sb_vld", 32'(gnt_valid), 32'd1);
        end
      end
      prev = gnt;
    end
  end

  initial begin
    logic [NUM_REQ-1:0] t2_exp [9];
    t2_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
               4'b0000, 4'b1000, 4'b0000, 4'b0001};

    // Reset holds everything idle even with all requests up.
    rst = 1'b1;
    req = 4'b1111;
    weight = 16'h1111;
    gnt_ready = 1'b1;
    gnt_last = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_vld", 32'(gnt_valid), 32'd0);
      chk("rst_id", 32'(gnt_id), 32'd0);
    end

    // Plain round robin with single-beat transfers and one idle bubble.
    do_reset();
    weight = 16'h1111;
    req = 4'b1111;
    gnt_ready = 1'b1;
    gnt_last = 1'b1;
    sb.push_back(4'b0001); sb.push_back(4'b0010);
    sb.push_back(4'b0100); sb.push_back(4'b1000);
    sb.push_back(4'b0001);
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("rr_seq%0d", i), 32'(gnt), 32'(t2_exp[i]));
    end
    req = '0;
    step(); step();

    // Weighted: requester 0 owns three transfers per turn, requester 1 one.
    do_reset();
    weight = 16'h1113;
    req = 4'b0011;
    gnt_ready = 1'b1;
    gnt_last = 1'b1;
    for (int r = 0; r < 2; r++) begin
      sb.push_back(4'b0001); sb.push_back(4'b0001);
      sb.push_back(4'b0001); sb.push_back(4'b0010);
    end
    for (int i = 0; i < 16; i++) step();
    req = '0;
    step(); step();

    // Hold under stall, then a four-beat transfer.
    do_reset();
    weight = 16'h1111;
    req = 4'b0001;
    sb.push_back(4'b0001);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("stall%0d", i), 32'(gnt), 32'b0001);
    end
    gnt_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("beat%0d", i), 32'(gnt), 32'b0001);
    end
    gnt_last = 1'b1;
    step();
    chk("hold_end", 32'(gnt), 32'd0);
    req = '0;
    gnt_last = 1'b0;
    step(); step();

    // Abort: requester 2 drops mid-transfer; pointer must move past it.
    do_reset();
    weight = 16'h1111;
    req = 4'b1100;
    gnt_ready = 1'b1;
    gnt_last = 1'b0;
    sb.push_back(4'b0100);
    sb.push_back(4'b1000);
    step();
    chk("abort_win", 32'(gnt), 32'b0100);
    step();
    chk("abort_beat1", 32'(gnt), 32'b0100);
    req = 4'b1001;
    step();
    chk("abort_drop", 32'(gnt), 32'd0);
    step();
    chk("abort_next", 32'(gnt), 32'b1000);
    gnt_last = 1'b1;
    req = '0;
    step(); step();

    // Reset mid-transfer restarts arbitration from requester 0.
    do_reset();
    weight = 16'h1111;
    req = 4'b0011;
    gnt_ready = 1'b1;
    gnt_last = 1'b1;
    sb.push_back(4'b0001);
    sb.push_back(4'b0010);
    sb.push_back(4'b0001);
    step();
    chk("mrst_first", 32'(gnt), 32'b0001);
    step();
    step();
    chk("mrst_busy", 32'(gnt), 32'b0010);
    gnt_ready = 1'b0;
    rst = 1'b1;
    step();
    chk("mrst_gnt", 32'(gnt), 32'd0);
    chk("mrst_vld", 32'(gnt_valid), 32'd0);
    chk("mrst_id", 32'(gnt_id), 32'd0);
    rst = 1'b0;
    gnt_ready = 1'b1;
    step();
    chk("mrst_after", 32'(gnt), 32'b0001);
    req = '0;
    step(); step();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
